// File: rtl/prbs_multilane_checker.sv
// -----------------------------------------------------------------------------
// prbs_multilane_checker
//
// Multi-lane PRBS receive checker. Each lane runs an independent
// HUNT -> SYNC -> LOCKED state machine:
//   HUNT   : self-synchronising; the expected word is the PRBS advance of the
//            previous received word.
//   SYNC   : the same self-synchronising compare, counting consecutive
//            matches until LOCK_CNT is reached.
//   LOCKED : a free-running internal LFSR, seeded from the word that
//            completed the lock, supplies the expected word. Bit errors are
//            counted into a saturating per-lane counter. UNLOCK_CNT
//            consecutive errored words drop the lane back to HUNT.
//
// Pipeline: the compare stage registers the FSM state and the per-word error
// popcount. The accumulate stage registers err_cnt, lane_locked and err_flag.
// err_clr is staged alongside the compare so that it lines up with the
// errors of the word it was presented with.
//
// Optional feature macro: PRBS_CHK_LED_STRETCH_EN
//   defined   : err_flag is stretched by a 24-bit per-lane down-counter that
//               reloads on every LOCKED error.
//   undefined : err_flag is a one-cycle pulse per errored LOCKED word.
//
// Ports
//   tmb_clock0  in   1                  clock, rising edge
//   reset       in   1                  synchronous active-high reset
//   prbs_mode   in   2                  00/11 PRBS-7, 01 PRBS-15, 10 PRBS-31
//   rx_valid    in   NUM_LANES          per-lane word strobe
//   rx_data     in   NUM_LANES*DATA_W   lane k at [k*DATA_W +: DATA_W],
//                                       bit 0 is the earliest bit in time
//   err_clr     in   1                  clear all error counters
//   lane_locked out  NUM_LANES          lane FSM is in LOCKED
//   err_cnt     out  NUM_LANES*ERR_W    saturating bit-error counts
//   err_flag    out  NUM_LANES          per-lane error indication (LED)
// -----------------------------------------------------------------------------
module prbs_multilane_checker #(
    parameter int NUM_LANES  = 4,
    parameter int DATA_W     = 32,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 8,
    parameter int ERR_W      = 32
) (
    input  logic                        tmb_clock0,
    input  logic                        reset,
    input  logic [1:0]                  prbs_mode,
    input  logic [NUM_LANES-1:0]        rx_valid,
    input  logic [NUM_LANES*DATA_W-1:0] rx_data,
    input  logic                        err_clr,
    output logic [NUM_LANES-1:0]        lane_locked,
    output logic [NUM_LANES*ERR_W-1:0]  err_cnt,
    output logic [NUM_LANES-1:0]        err_flag
);

    localparam int POP_W = $clog2(DATA_W + 1);
    localparam int MC_W  = $clog2(LOCK_CNT + 1);
    localparam int UC_W  = $clog2(UNLOCK_CNT + 1);
    localparam int SUM_W = ((ERR_W > POP_W) ? ERR_W : POP_W) + 1;

    localparam logic [MC_W-1:0]  LOCK_V   = MC_W'(LOCK_CNT);
    localparam logic [MC_W-1:0]  MC_ONE   = MC_W'(1);
    localparam logic [UC_W-1:0]  UNLOCK_V = UC_W'(UNLOCK_CNT);
    localparam logic [UC_W-1:0]  UC_ONE   = UC_W'(1);
    localparam logic [SUM_W-1:0] CNT_MAX  = {{(SUM_W-ERR_W){1'b0}}, {ERR_W{1'b1}}};

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } lane_state_e;

    // Next DATA_W bits of the sequence that follows 'prev'. The stream is
    // laid out with prev in the low half and the new word in the high half;
    // each new bit is the XOR of two earlier stream bits. DATA_W >= 31, so
    // every tap of the longest polynomial falls inside this window.
    function automatic logic [DATA_W-1:0] prbs_next(input logic [DATA_W-1:0] prev,
                                                    input logic [1:0]        mode);
        logic [2*DATA_W-1:0] s7;
        logic [2*DATA_W-1:0] s15;
        logic [2*DATA_W-1:0] s31;
        logic [DATA_W-1:0]   nxt;
        s7  = {{DATA_W{1'b0}}, prev};
        s15 = s7;
        s31 = s7;
        for (int i = DATA_W; i < 2*DATA_W; i++) begin
            s7[i]  = s7[i-6]   ^ s7[i-7];
            s15[i] = s15[i-14] ^ s15[i-15];
            s31[i] = s31[i-28] ^ s31[i-31];
        end
        case (mode)
            2'b01:   nxt = s15[2*DATA_W-1:DATA_W];
            2'b10:   nxt = s31[2*DATA_W-1:DATA_W];
            default: nxt = s7[2*DATA_W-1:DATA_W];
        endcase
        return nxt;
    endfunction

    // Number of set bits in a lane word.
    function automatic logic [POP_W-1:0] popcount(input logic [DATA_W-1:0] v);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_W; i++) begin
            c = c + {{(POP_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic [1:0] mode_q;
    logic       clr_q;
    logic       mode_chg_s;

    // Any change of polynomial restarts acquisition on every lane.
    assign mode_chg_s = (prbs_mode != mode_q);

    // Track the active polynomial and stage err_clr to line up with the compare results.
    always_ff @(posedge tmb_clock0) begin
        if (reset) begin
            mode_q <= 2'b00;
            clr_q  <= 1'b0;
        end else begin
            mode_q <= prbs_mode;
            clr_q  <= err_clr;
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [DATA_W-1:0] rx_s;
        logic [DATA_W-1:0] exp_hunt_s;
        logic [DATA_W-1:0] exp_lock_s;
        logic              hunt_hit_s;
        logic              lock_hit_s;
        logic [MC_W-1:0]   match_inc_s;
        logic [UC_W-1:0]   miss_inc_s;

        lane_state_e       state_q;
        logic [DATA_W-1:0] prev_q;
        logic [DATA_W-1:0] lfsr_q;
        logic [MC_W-1:0]   match_q;
        logic [UC_W-1:0]   miss_q;
        logic [POP_W-1:0]  pop_q;
        logic              err_q;

        logic [SUM_W-1:0]  sum_s;
        logic [ERR_W-1:0]  cnt_d;
        logic [ERR_W-1:0]  cnt_q;
        logic              locked_q;
        logic              flag_q;

        assign rx_s        = rx_data[k*DATA_W +: DATA_W];
        assign exp_hunt_s  = prbs_next(prev_q, mode_q);
        assign exp_lock_s  = prbs_next(lfsr_q, mode_q);
        assign hunt_hit_s  = (rx_s == exp_hunt_s);
        assign lock_hit_s  = (rx_s == exp_lock_s);
        assign match_inc_s = match_q + MC_ONE;
        assign miss_inc_s  = miss_q + UC_ONE;

        // Compare stage: lane FSM plus this word's LOCKED bit-error count.
        always_ff @(posedge tmb_clock0) begin
            if (reset) begin
                state_q <= ST_HUNT;
                prev_q  <= '0;
                lfsr_q  <= '0;
                match_q <= '0;
                miss_q  <= '0;
                pop_q   <= '0;
                err_q   <= 1'b0;
            end else begin
                pop_q <= '0;
                err_q <= 1'b0;
                if (rx_valid[k]) begin
                    prev_q <= rx_s;
                end
                if (mode_chg_s) begin
                    // The word arriving with the change only primes prev_q.
                    state_q <= ST_HUNT;
                    match_q <= '0;
                    miss_q  <= '0;
                end else if (rx_valid[k]) begin
                    case (state_q)
                        ST_HUNT: begin
                            miss_q <= '0;
                            if (hunt_hit_s) begin
                                if (LOCK_V <= MC_ONE) begin
                                    state_q <= ST_LOCKED;
                                    lfsr_q  <= rx_s;
                                    match_q <= '0;
                                end else begin
                                    state_q <= ST_SYNC;
                                    match_q <= MC_ONE;
                                end
                            end else begin
                                state_q <= ST_HUNT;
                                match_q <= '0;
                            end
                        end
                        ST_SYNC: begin
                            miss_q <= '0;
                            if (hunt_hit_s) begin
                                if (match_inc_s >= LOCK_V) begin
                                    // The matching word seeds the LFSR.
                                    state_q <= ST_LOCKED;
                                    lfsr_q  <= rx_s;
                                    match_q <= '0;
                                end else begin
                                    state_q <= ST_SYNC;
                                    match_q <= match_inc_s;
                                end
                            end else begin
                                state_q <= ST_HUNT;
                                match_q <= '0;
                            end
                        end
                        ST_LOCKED: begin
                            // The LFSR free-runs on its own prediction so
                            // received errors never corrupt the reference.
                            lfsr_q  <= exp_lock_s;
                            pop_q   <= popcount(rx_s ^ exp_lock_s);
                            err_q   <= !lock_hit_s;
                            match_q <= '0;
                            if (lock_hit_s) begin
                                miss_q <= '0;
                            end else if (miss_inc_s >= UNLOCK_V) begin
                                state_q <= ST_HUNT;
                                miss_q  <= '0;
                            end else begin
                                miss_q <= miss_inc_s;
                            end
                        end
                        default: begin
                            state_q <= ST_HUNT;
                            match_q <= '0;
                            miss_q  <= '0;
                        end
                    endcase
                end else begin
                    state_q <= state_q;
                end
            end
        end

        // Saturating accumulate; a staged clear wins and drops the same-cycle errors.
        always_comb begin
            sum_s = SUM_W'(cnt_q) + SUM_W'(pop_q);
            if (clr_q) begin
                cnt_d = '0;
            end else if (sum_s > CNT_MAX) begin
                cnt_d = {ERR_W{1'b1}};
            end else begin
                cnt_d = sum_s[ERR_W-1:0];
            end
        end

        // Accumulate stage: error counter and lock indication.
        always_ff @(posedge tmb_clock0) begin
            if (reset) begin
                cnt_q    <= '0;
                locked_q <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                locked_q <= (state_q == ST_LOCKED) && !mode_chg_s;
            end
        end

`ifdef PRBS_CHK_LED_STRETCH_EN
        logic [23:0] stretch_d;
        logic [23:0] stretch_q;

        // LED stretch: reload on every LOCKED error, then count down to zero.
        always_comb begin
            if (err_q) begin
                stretch_d = 24'hFF_FFFF;
            end else if (stretch_q != 24'd0) begin
                stretch_d = stretch_q - 24'd1;
            end else begin
                stretch_d = 24'd0;
            end
        end

        // Stretch counter and the flag it drives.
        always_ff @(posedge tmb_clock0) begin
            if (reset) begin
                stretch_q <= 24'd0;
                flag_q    <= 1'b0;
            end else begin
                stretch_q <= stretch_d;
                flag_q    <= (stretch_d != 24'd0);
            end
        end
`else
        // One-cycle error pulse per errored LOCKED word.
        always_ff @(posedge tmb_clock0) begin
            if (reset) begin
                flag_q <= 1'b0;
            end else begin
                flag_q <= err_q;
            end
        end
`endif

        assign lane_locked[k]                = locked_q;
        assign err_cnt[k*ERR_W +: ERR_W]     = cnt_q;
        assign err_flag[k]                   = flag_q;
    end

endmodule

// File: tb/tb_prbs_multilane_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs_multilane_checker
//
// Directed bench for prbs_multilane_checker (4 lanes, 32-bit words,
// LOCK_CNT 16, UNLOCK_CNT 8, ERR_W 4). Lane streams come from a bit-serial
// reference generator using the defining recurrence of each polynomial.
// Inputs are driven 1 time unit after a rising edge and outputs are sampled
// at the same point, so an output reflects the word sampled two edges back.
// -----------------------------------------------------------------------------
module tb_prbs_multilane_checker;

    localparam int NL = 4;
    localparam int DW = 32;
    localparam int EW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        prbs_mode;
    logic [NL-1:0]     rx_valid;
    logic [NL*DW-1:0]  rx_data;
    logic              err_clr;
    logic [NL-1:0]     lane_locked;
    logic [NL*EW-1:0]  err_cnt;
    logic [NL-1:0]     err_flag;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [30:0] win [NL];       // win[j] = bit emitted j+1 steps ago
    int          flip_lane = -1;
    logic [31:0] flip_bits = 32'd0;
    logic [NL-1:0] zero_mask = '0;
    int          zero_pop = 0;
    logic [NL-1:0] flag_seen = '0;
    int          exp0;
    logic [3:0]  flag_after;

    always #5 clk = ~clk;

    prbs_multilane_checker #(
        .NUM_LANES (NL),
        .DATA_W    (DW),
        .LOCK_CNT  (16),
        .UNLOCK_CNT(8),
        .ERR_W     (EW)
    ) u_dut (
        .tmb_clock0 (clk),
        .reset      (reset),
        .prbs_mode  (prbs_mode),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .err_clr    (err_clr),
        .lane_locked(lane_locked),
        .err_cnt    (err_cnt),
        .err_flag   (err_flag)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference: produce the next 32 bits of a lane's stream.
    task automatic gen_word(input int lane, output logic [31:0] w);
        logic b;
        for (int i = 0; i < 32; i++) begin
            case (prbs_mode)
                2'b01:   b = win[lane][13] ^ win[lane][14];
                2'b10:   b = win[lane][27] ^ win[lane][30];
                default: b = win[lane][5]  ^ win[lane][6];
            endcase
            w[i] = b;
            win[lane] = {win[lane][29:0], b};
        end
    endtask

    // Present one word per lane (valid lanes only), then advance one clock.
    task automatic drive_cycle(input logic [NL-1:0] vld);
        logic [31:0] w;
        for (int k = 0; k < NL; k++) begin
            if (vld[k]) begin
                gen_word(k, w);
                if (zero_mask[k]) begin
                    zero_pop += $countones(w);
                    w = 32'd0;
                end
                if (flip_lane == k) w = w ^ flip_bits;
                rx_data[k*DW +: DW] = w;
            end else begin
                rx_data[k*DW +: DW] = 32'hDEAD_BEEF;
            end
        end
        rx_valid = vld;
        @(posedge clk);
        #1;
        flag_seen = flag_seen | err_flag;
    endtask

    initial begin
        reset     = 1'b1;
        prbs_mode = 2'b00;
        rx_valid  = '0;
        rx_data   = '0;
        err_clr   = 1'b0;
        win[0] = 31'h1234_5679;
        win[1] = 31'h2468_ACE1;
        win[2] = 31'h0F0F_0F53;
        win[3] = 31'h7654_321B;
`ifdef PRBS_CHK_LED_STRETCH_EN
        flag_after = 4'b0100;
`else
        flag_after = 4'b0000;
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_locked", 32'(lane_locked), 32'h0);
        check_eq("rst_cnt",    32'(err_cnt),     32'h0);
        check_eq("rst_flag",   32'(err_flag),    32'h0);
        reset = 1'b0;

        // Clean PRBS-7: word 17 completes the lock, visible after word 18
        repeat (17) drive_cycle(4'hF);
        check_eq("p7_17w_unlocked", 32'(lane_locked), 32'h0);
        drive_cycle(4'hF);
        check_eq("p7_18w_locked", 32'(lane_locked), 32'hF);
        flag_seen = '0;
        repeat (982) drive_cycle(4'hF);
        check_eq("p7_1000w_locked", 32'(lane_locked), 32'hF);
        check_eq("p7_1000w_cnt",    32'(err_cnt),     32'h0);
        check_eq("p7_1000w_noflag", 32'(flag_seen),   32'h0);

        // Mode change 00 -> 01: unlock next cycle, relock on PRBS-15
        prbs_mode = 2'b01;
        drive_cycle(4'hF);
        check_eq("m01_unlock", 32'(lane_locked), 32'h0);
        repeat (16) drive_cycle(4'hF);
        check_eq("m01_not_yet", 32'(lane_locked), 32'h0);
        drive_cycle(4'hF);
        check_eq("m01_relock", 32'(lane_locked), 32'hF);
        check_eq("m01_cnt_kept", 32'(err_cnt), 32'h0);

        // PRBS-31, lane 2 gets bits 0 and 5 flipped in one word
        prbs_mode = 2'b10;
        drive_cycle(4'hF);
        check_eq("m10_unlock", 32'(lane_locked), 32'h0);
        repeat (17) drive_cycle(4'hF);
        check_eq("m10_relock", 32'(lane_locked), 32'hF);
        flip_lane = 2;
        flip_bits = 32'h0000_0021;
        drive_cycle(4'hF);
        flip_lane = -1;
        drive_cycle(4'hF);
        check_eq("l2_cnt2",   32'(err_cnt[11:8]), 32'd2);
        check_eq("l2_flag",   32'(err_flag),      32'h4);
        check_eq("l2_others", 32'(err_cnt & 16'hF0FF), 32'h0);
        drive_cycle(4'hF);
        check_eq("l2_flag_end", 32'(err_flag),    32'(flag_after));
        check_eq("l2_locked",   32'(lane_locked), 32'hF);

        // Lane 0: 8 all-zero words force HUNT, then relock on clean data
        zero_mask = 4'b0001;
        zero_pop  = 0;
        repeat (8) drive_cycle(4'hF);
        check_eq("l0_7zero_locked", 32'(lane_locked), 32'hF);
        zero_mask = '0;
        drive_cycle(4'hF);
        check_eq("l0_unlocked", 32'(lane_locked), 32'hE);
        exp0 = (zero_pop > 15) ? 15 : zero_pop;
        check_eq("l0_cnt_sat", 32'(err_cnt[3:0]), 32'(exp0));
        repeat (16) drive_cycle(4'hF);
        check_eq("l0_relock_17", 32'(lane_locked), 32'hE);
        drive_cycle(4'hF);
        check_eq("l0_relock_18", 32'(lane_locked), 32'hF);
        check_eq("l0_l2_kept",   32'(err_cnt[11:8]), 32'd2);

        // err_clr takes effect two cycles later
        err_clr = 1'b1;
        drive_cycle(4'hF);
        err_clr = 1'b0;
        check_eq("clr_pending", 32'(err_cnt[3:0]), 32'(exp0));
        drive_cycle(4'hF);
        check_eq("clr_done", 32'(err_cnt), 32'h0);

        // Lane 1: single-bit errors; lane 3 idle with garbage on its data
        for (int i = 0; i < 10; i++) begin
            flip_lane = 1;
            flip_bits = 32'd1 << i;
            drive_cycle(4'b0111);
            flip_lane = -1;
            drive_cycle(4'b0111);
        end
        check_eq("l1_cnt10",    32'(err_cnt[7:4]),   32'd10);
        check_eq("l3_idle_cnt", 32'(err_cnt[15:12]), 32'd0);
        check_eq("l3_idle_lock", 32'(lane_locked),   32'hF);
        for (int i = 10; i < 20; i++) begin
            flip_lane = 1;
            flip_bits = 32'd1 << i;
            drive_cycle(4'hF);
            flip_lane = -1;
            drive_cycle(4'hF);
        end
        check_eq("l1_cnt_sat", 32'(err_cnt[7:4]), 32'd15);
        check_eq("l1_locked",  32'(lane_locked),  32'hF);

        // err_clr coincident with an error discards that error
        flip_lane = 1;
        flip_bits = 32'h0000_0001;
        err_clr   = 1'b1;
        drive_cycle(4'hF);
        err_clr   = 1'b0;
        flip_lane = -1;
        drive_cycle(4'hF);
        check_eq("clr_with_err", 32'(err_cnt[7:4]), 32'd0);
        flip_lane = 1;
        drive_cycle(4'hF);
        flip_lane = -1;
        drive_cycle(4'hF);
        check_eq("l1_cnt1", 32'(err_cnt[7:4]), 32'd1);

        // Reset mid-operation overrides valid, errors and err_clr
        flip_lane = 1;
        drive_cycle(4'hF);
        reset   = 1'b1;
        err_clr = 1'b1;
        drive_cycle(4'hF);
        check_eq("mid_rst_locked", 32'(lane_locked), 32'h0);
        check_eq("mid_rst_cnt",    32'(err_cnt),     32'h0);
        check_eq("mid_rst_flag",   32'(err_flag),    32'h0);
        reset     = 1'b0;
        err_clr   = 1'b0;
        flip_lane = -1;
        repeat (2) drive_cycle(4'hF);
        check_eq("post_rst_hunt", 32'(lane_locked), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
